// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with configurable framing, majority voting and a
// single-entry valid/ready output buffer carrying per-word error flags.
module uart_rx_framed #(
    parameter int N           = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         rx,
    output logic [N-1:0] data_out,
    output logic         valid,
    input  logic         ready,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy,
    output logic [2:0]   state_leds
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SAMP_A  = CW'(OVERSAMPLE - 3);
    localparam logic [CW-1:0] SAMP_B  = CW'(OVERSAMPLE - 2);
    localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);
    localparam logic [3:0] DATA_LAST  = 4'(N - 1);
    localparam logic [3:0] STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic ODD_PARITY       = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [3:0]      bit_cnt_reg, bit_cnt_next;
    logic [N-1:0]    shift_reg, shift_next;
    logic [1:0]      samp_reg, samp_next;
    logic            perr_reg, perr_next;
    logic            ferr_reg, ferr_next;
    logic            done_reg, done_next;
    logic            done_ferr_reg, done_ferr_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;
    logic                   voted;

    logic [N-1:0] data_out_reg;
    logic         valid_reg;
    logic         parity_err_reg;
    logic         frame_err_reg;
    logic         overrun_reg;

    // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s  = sync_reg[SYNC_STAGES-1];
    assign voted = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            samp_reg      <= '0;
            perr_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
            done_reg      <= 1'b0;
            done_ferr_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_cnt_reg  <= tick_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            samp_reg      <= samp_next;
            perr_reg      <= perr_next;
            ferr_reg      <= ferr_next;
            done_reg      <= done_next;
            done_ferr_reg <= done_ferr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tick_cnt_next  = tick_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        samp_next      = samp_reg;
        perr_next      = perr_reg;
        ferr_next      = ferr_reg;
        done_next      = 1'b0;
        done_ferr_next = done_ferr_reg;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (tick_cnt_reg == HALF_M1) begin
                        tick_cnt_next = '0;
                        if (!rx_s) begin
                            state_next   = DATA;
                            bit_cnt_next = '0;
                            perr_next    = 1'b0;
                            ferr_next    = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
            end

            DATA, PARITY, STOP: begin
                if (tick) begin
                    tick_cnt_next = (tick_cnt_reg == LAST) ? '0 : tick_cnt_reg + 1'b1;
                    if (tick_cnt_reg == SAMP_A) samp_next[0] = rx_s;
                    if (tick_cnt_reg == SAMP_B) samp_next[1] = rx_s;

                    // Third sample is taken live; the bit is decided on this tick.
                    if (tick_cnt_reg == LAST) begin
                        if (state_reg == DATA) begin
                            shift_next = {voted, shift_reg[N-1:1]};
                            if (bit_cnt_reg == DATA_LAST) begin
                                bit_cnt_next = '0;
                                state_next   = (PARITY_MODE != 0) ? PARITY : STOP;
                            end else begin
                                bit_cnt_next = bit_cnt_reg + 1'b1;
                            end
                        end else if (state_reg == PARITY) begin
                            perr_next    = (^shift_reg) ^ voted ^ ODD_PARITY;
                            bit_cnt_next = '0;
                            state_next   = STOP;
                        end else begin
                            if (!voted) ferr_next = 1'b1;
                            if (bit_cnt_reg == STOP_LAST) begin
                                bit_cnt_next   = '0;
                                state_next     = IDLE;
                                done_next      = 1'b1;
                                done_ferr_next = ferr_reg | ~voted;
                            end else begin
                                bit_cnt_next = bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output buffer: a completed frame is taken only if the slot is free or being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg   <= '0;
            valid_reg      <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (done_reg) begin
            if (!valid_reg || ready) begin
                data_out_reg   <= shift_reg;
                parity_err_reg <= perr_reg;
                frame_err_reg  <= done_ferr_reg;
                valid_reg      <= 1'b1;
                overrun_reg    <= 1'b0;
            end else begin
                overrun_reg <= 1'b1;
            end
        end else if (valid_reg && ready) begin
            valid_reg      <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end
    end

    assign data_out   = data_out_reg;
    assign valid      = valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);
    assign state_leds = state_reg;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: four instances cover no-parity, even, odd
// and two-stop-bit framing; frames are driven bit by bit against the tick strobe.
module tb_uart_rx_framed;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [2:0] rx_line;
    logic       ready_w [4];
    logic [7:0] data_w  [4];
    logic       valid_w [4];
    logic       pe_w    [4];
    logic       fe_w    [4];
    logic       ov_w    [4];
    logic       busy_w  [4];
    logic [2:0] leds_w  [4];

    int checks = 0;
    int errors = 0;
    int div    = 0;

    int         cap_cnt  [4];
    logic [7:0] cap_data [4];
    logic       cap_pe   [4];
    logic       cap_fe   [4];
    logic       cap_ov   [4];

    uart_rx_framed u_plain (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_line[0]),
        .data_out(data_w[0]), .valid(valid_w[0]), .ready(ready_w[0]),
        .parity_err(pe_w[0]), .frame_err(fe_w[0]), .overrun(ov_w[0]),
        .busy(busy_w[0]), .state_leds(leds_w[0])
    );

    uart_rx_framed #(.PARITY_MODE(1)) u_even (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_line[1]),
        .data_out(data_w[1]), .valid(valid_w[1]), .ready(ready_w[1]),
        .parity_err(pe_w[1]), .frame_err(fe_w[1]), .overrun(ov_w[1]),
        .busy(busy_w[1]), .state_leds(leds_w[1])
    );

    uart_rx_framed #(.PARITY_MODE(2)) u_odd (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_line[1]),
        .data_out(data_w[2]), .valid(valid_w[2]), .ready(ready_w[2]),
        .parity_err(pe_w[2]), .frame_err(fe_w[2]), .overrun(ov_w[2]),
        .busy(busy_w[2]), .state_leds(leds_w[2])
    );

    uart_rx_framed #(.STOP_BITS(2)) u_stop2 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_line[2]),
        .data_out(data_w[3]), .valid(valid_w[3]), .ready(ready_w[3]),
        .parity_err(pe_w[3]), .frame_err(fe_w[3]), .overrun(ov_w[3]),
        .busy(busy_w[3]), .state_leds(leds_w[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every fourth clock, changed on the falling edge.
    initial tick = 1'b0;
    always @(negedge clk) begin
        div  = (div == 3) ? 0 : div + 1;
        tick = (div == 0);
    end

    // Records every accepted word so pulse counts and contents can be checked later.
    initial begin
        for (int k = 0; k < 4; k++) begin
            cap_cnt[k]  = 0;
            cap_data[k] = '0;
            cap_pe[k]   = 1'b0;
            cap_fe[k]   = 1'b0;
            cap_ov[k]   = 1'b0;
        end
    end
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (valid_w[k] && ready_w[k]) begin
                cap_cnt[k]  <= cap_cnt[k] + 1;
                cap_data[k] <= data_w[k];
                cap_pe[k]   <= pe_w[k];
                cap_fe[k]   <= fe_w[k];
                cap_ov[k]   <= ov_w[k];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!tick);
        end
        @(negedge clk);
    endtask

    // par < 0 means no parity bit; the last stop bit is held 10 ticks, then the line idles.
    task automatic send_frame(input int line, input logic [7:0] d, input int par,
                              input int nstop, input logic [1:0] stops, input int glitch);
        $display("frame line=%0d data=%02h par=%0d stops=%b glitch=%0d", line, d, par, stops, glitch);
        rx_line[line] = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx_line[line] = d[i];
            if (i == glitch) begin
                wait_ticks(6);
                rx_line[line] = 1'b0;
                wait_ticks(1);
                rx_line[line] = d[i];
                wait_ticks(9);
            end else begin
                wait_ticks(16);
            end
        end
        if (par >= 0) begin
            rx_line[line] = par[0];
            wait_ticks(16);
        end
        for (int s = 0; s < nstop; s++) begin
            rx_line[line] = stops[s];
            wait_ticks((s == nstop - 1) ? 10 : 16);
        end
        rx_line[line] = 1'b1;
        wait_ticks(10);
    endtask

    int prev;

    initial begin
        reset   = 1'b1;
        rx_line = 3'b111;
        for (int k = 0; k < 4; k++) ready_w[k] = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;

        check("rst_state", 32'(leds_w[0]), 32'd0);
        check("rst_busy", 32'(busy_w[0]), 32'd0);
        check("rst_valid", 32'(valid_w[0]), 32'd0);
        check("rst_data", 32'(data_w[0]), 32'h00);
        check("rst_flags", {29'd0, pe_w[0], fe_w[0], ov_w[0]}, 32'd0);
        wait_ticks(2);

        // Plain 8N1 words with a consumer that is always ready.
        prev = cap_cnt[0];
        send_frame(0, 8'h55, -1, 1, 2'b11, -1);
        check("w55_data", 32'(cap_data[0]), 32'h55);
        check("w55_pulses", 32'(cap_cnt[0] - prev), 32'd1);
        check("w55_flags", {30'd0, cap_pe[0], cap_fe[0]}, 32'd0);
        check("w55_valid_low", 32'(valid_w[0]), 32'd0);
        send_frame(0, 8'hA3, -1, 1, 2'b11, -1);
        check("wA3_data", 32'(cap_data[0]), 32'hA3);
        check("wA3_pulses", 32'(cap_cnt[0] - prev), 32'd2);
        check("wA3_flags", {29'd0, cap_pe[0], cap_fe[0], cap_ov[0]}, 32'd0);

        // 0x07 has odd weight: parity bit 0 is wrong for even, right for odd.
        send_frame(1, 8'h07, 0, 1, 2'b11, -1);
        check("even_p0_data", 32'(cap_data[1]), 32'h07);
        check("even_p0_perr", 32'(cap_pe[1]), 32'd1);
        check("odd_p0_data", 32'(cap_data[2]), 32'h07);
        check("odd_p0_perr", 32'(cap_pe[2]), 32'd0);
        send_frame(1, 8'h07, 1, 1, 2'b11, -1);
        check("even_p1_perr", 32'(cap_pe[1]), 32'd0);
        check("odd_p1_perr", 32'(cap_pe[2]), 32'd1);
        check("even_p1_ferr", 32'(cap_fe[1]), 32'd0);
        check("parity_words", 32'(cap_cnt[1] + cap_cnt[2]), 32'd4);

        // Two stop bits: a good frame, then one with the second stop bit low.
        send_frame(2, 8'h3C, -1, 2, 2'b11, -1);
        check("stop2_ok_data", 32'(cap_data[3]), 32'h3C);
        check("stop2_ok_ferr", 32'(cap_fe[3]), 32'd0);
        send_frame(2, 8'h5A, -1, 2, 2'b01, -1);
        check("stop2_bad_data", 32'(cap_data[3]), 32'h5A);
        check("stop2_bad_ferr", 32'(cap_fe[3]), 32'd1);
        check("stop2_words", 32'(cap_cnt[3]), 32'd2);

        // False start: four ticks low is shorter than half a bit.
        prev = cap_cnt[0];
        rx_line[0] = 1'b0;
        wait_ticks(4);
        check("fstart_in_start", 32'(leds_w[0]), 32'd1);
        check("fstart_busy", 32'(busy_w[0]), 32'd1);
        rx_line[0] = 1'b1;
        wait_ticks(12);
        check("fstart_idle", 32'(leds_w[0]), 32'd0);
        check("fstart_no_word", 32'(cap_cnt[0] - prev), 32'd0);
        check("fstart_valid", 32'(valid_w[0]), 32'd0);

        // Single-tick glitch on the middle sample of a '1' data bit is voted out.
        send_frame(0, 8'h04, -1, 1, 2'b11, 2);
        check("glitch_data", 32'(cap_data[0]), 32'h04);
        send_frame(0, 8'hFF, -1, 1, 2'b11, 5);
        check("glitch_ff_data", 32'(cap_data[0]), 32'hFF);

        // Overrun: consumer stalled across two frames.
        ready_w[0] = 1'b0;
        prev = cap_cnt[0];
        send_frame(0, 8'h11, -1, 1, 2'b11, -1);
        check("ovr_first_valid", 32'(valid_w[0]), 32'd1);
        check("ovr_first_data", 32'(data_w[0]), 32'h11);
        check("ovr_first_flag", 32'(ov_w[0]), 32'd0);
        send_frame(0, 8'h22, -1, 1, 2'b11, -1);
        check("ovr_held_data", 32'(data_w[0]), 32'h11);
        check("ovr_flag", 32'(ov_w[0]), 32'd1);
        check("ovr_held_valid", 32'(valid_w[0]), 32'd1);
        @(posedge clk);
        #1 ready_w[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("drain_valid", 32'(valid_w[0]), 32'd0);
        check("drain_ovr", 32'(ov_w[0]), 32'd0);
        check("drain_word", 32'(cap_data[0]), 32'h11);
        check("drain_ovr_seen", 32'(cap_ov[0]), 32'd1);
        check("drain_pulses", 32'(cap_cnt[0] - prev), 32'd1);
        wait_ticks(2);
        send_frame(0, 8'h33, -1, 1, 2'b11, -1);
        check("post_ovr_data", 32'(cap_data[0]), 32'h33);
        check("post_ovr_flag", 32'(cap_ov[0]), 32'd0);

        // Reset pulse in the middle of data bit 3 (line high there).
        prev = cap_cnt[0];
        rx_line[0] = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx_line[0] = 1'b1;
            wait_ticks(16);
        end
        wait_ticks(5);
        check("pre_rst_data_state", 32'(leds_w[0]), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_state", 32'(leds_w[0]), 32'd0);
        check("mid_rst_valid", 32'(valid_w[0]), 32'd0);
        check("mid_rst_data", 32'(data_w[0]), 32'h00);
        wait_ticks(20);
        check("mid_rst_no_word", 32'(cap_cnt[0] - prev), 32'd0);
        send_frame(0, 8'hC4, -1, 1, 2'b11, -1);
        check("after_rst_data", 32'(cap_data[0]), 32'hC4);
        check("after_rst_pulses", 32'(cap_cnt[0] - prev), 32'd1);
        check("after_rst_flags", {29'd0, cap_pe[0], cap_fe[0], cap_ov[0]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
